// File: rtl/seq_divider.sv
// Sequential radix-2 signed divider. Restoring division on operand magnitudes,
// one quotient bit per clock, with the signs re-applied in a final FIX cycle.
// Quotient truncates toward zero and the remainder takes the sign of the dividend.
module seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         ready,
    output logic         busy,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LastCnt = CW'(N);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    // The partial remainder never exceeds |B| <= 2^(N-1), so the top bit of the
    // N+1-bit remainder is always zero and is not stored; the shifted value and the
    // trial difference are carried at full N+1 bits.
    logic [N-1:0]   r_p, w_p_nxt;
    logic [N-1:0]   r_m, w_m_nxt;
    logic [N-1:0]   r_b_mag, w_b_mag_nxt;
    logic           r_sign_q, w_sign_q_nxt;
    logic           r_sign_r, w_sign_r_nxt;
    logic [N-1:0]   r_q, w_q_nxt;
    logic [N-1:0]   r_r, w_r_nxt;
    logic           r_ready, w_ready_nxt;
    logic           r_dbz, w_dbz_nxt;

    // Unsigned magnitudes; -2^(N-1) maps to 2^(N-1), which fits N unsigned bits.
    logic [N-1:0]   w_a_mag, w_b_mag;
    logic           w_b_zero;
    logic [N:0]     w_p_sh;
    logic [N:0]     w_t;
    logic [N-1:0]   w_m_sh;

    assign w_a_mag  = A[N-1] ? -A : A;
    assign w_b_mag  = B[N-1] ? -B : B;
    assign w_b_zero = (B == '0);

    // One restoring step: shift {P,M} left by one and trial-subtract |B|.
    assign w_p_sh = {r_p, r_m[N-1]};
    assign w_m_sh = {r_m[N-2:0], 1'b0};
    assign w_t    = w_p_sh - {1'b0, r_b_mag};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_p      <= '0;
            r_m      <= '0;
            r_b_mag  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_ready  <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_p      <= w_p_nxt;
            r_m      <= w_m_nxt;
            r_b_mag  <= w_b_mag_nxt;
            r_sign_q <= w_sign_q_nxt;
            r_sign_r <= w_sign_r_nxt;
            r_q      <= w_q_nxt;
            r_r      <= w_r_nxt;
            r_ready  <= w_ready_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    // Next-state and datapath update; everything holds unless a state says otherwise.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_p_nxt      = r_p;
        w_m_nxt      = r_m;
        w_b_mag_nxt  = r_b_mag;
        w_sign_q_nxt = r_sign_q;
        w_sign_r_nxt = r_sign_r;
        w_q_nxt      = r_q;
        w_r_nxt      = r_r;
        w_ready_nxt  = r_ready;
        w_dbz_nxt    = r_dbz;

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    if (w_b_zero) begin
                        w_state_nxt = StDone;
                        w_q_nxt     = '1;
                        w_r_nxt     = A;
                        w_ready_nxt = 1'b1;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt  = StIter;
                        w_cnt_nxt    = '0;
                        w_p_nxt      = '0;
                        w_m_nxt      = w_a_mag;
                        w_b_mag_nxt  = w_b_mag;
                        w_sign_q_nxt = A[N-1] ^ B[N-1];
                        w_sign_r_nxt = A[N-1];
                        w_ready_nxt  = 1'b0;
                        w_dbz_nxt    = 1'b0;
                    end
                end
            end
            StIter: begin
                // The terminal-count cycle after the N-th step aligns the latency
                // with the multiplier's N+2 edges.
                if (r_cnt == LastCnt) begin
                    w_state_nxt = StFix;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (!w_t[N]) begin
                        w_p_nxt = w_t[N-1:0];
                        w_m_nxt = {w_m_sh[N-1:1], 1'b1};
                    end else begin
                        w_p_nxt = w_p_sh[N-1:0];
                        w_m_nxt = w_m_sh;
                    end
                end
            end
            StFix: begin
                w_q_nxt     = r_sign_q ? -r_m : r_m;
                w_r_nxt     = r_sign_r ? -r_p : r_p;
                w_ready_nxt = 1'b1;
                w_state_nxt = StDone;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign Q           = r_q;
    assign R           = r_r;
    assign ready       = r_ready;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == StIter) || (r_state == StFix);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8): directed sign/edge cases, reset
// mid-operation, ignored start, back-to-back start, and randomized operands
// compared against plain integer division.
module tb_seq_divider;

    localparam int unsigned N = 8;
    localparam int NormLat = N + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         ready;
    logic         busy;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;
    int n_overlap = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .ready       (ready),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ready === 1'b1 && busy === 1'b1) n_overlap++;
    end

    // Reference: truncating signed division, remainder sign follows dividend.
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic z);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = N'(sa / sb);
            r = N'(sa % sb);
            z = 1'b0;
        end
    endtask

    // Present operands with start for exactly one edge, then scramble operands.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = N'($urandom);
        B = N'($urandom);
    endtask

    // Count edges until ready; bounded so a stuck design still reaches the summary.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({Q, R, ready, busy, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL reset: got Q=%h R=%h rdy=%b busy=%b dbz=%b want all 0",
                     Q, R, ready, busy, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [9] = '{8'd100, 8'd156, 8'd100, 8'd156, 8'h80, 8'h80, 8'd5, 8'd0, 8'd37};
        logic [N-1:0] tb [9] = '{8'd7, 8'd7, 8'hF9, 8'hF9, 8'hFF, 8'h01, 8'd9, 8'hFD, 8'd0};
        logic [N-1:0] eq [9] = '{8'h0E, 8'hF2, 8'hF2, 8'h0E, 8'h80, 8'h80, 8'h00, 8'h00, 8'hFF};
        logic [N-1:0] er [9] = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h05, 8'h00, 8'h25};
        logic         ez [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        int elat;
        for (int i = 0; i < 9; i++) begin
            start_op(ta[i], tb[i]);
            if (!ez[i]) begin
                total++;
                if (busy !== 1'b1 || ready !== 1'b0) begin
                    bad++;
                    $display("FAIL dir%0d_accept: got busy=%b rdy=%b want busy=1 rdy=0",
                             i, busy, ready);
                end
            end
            wait_ready(lat);
            elat = ez[i] ? 0 : NormLat;
            total++;
            if (lat !== elat) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat);
            end
            total++;
            if ({Q, R, div_by_zero} !== {eq[i], er[i], ez[i]}) begin
                bad++;
                $display("FAIL dir%0d %0d/%0d: got Q=%h R=%h dbz=%b want Q=%h R=%h dbz=%b",
                         i, $signed(ta[i]), $signed(tb[i]), Q, R, div_by_zero,
                         eq[i], er[i], ez[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(8'd100, 8'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({Q, R, ready, busy, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got Q=%h R=%h rdy=%b busy=%b dbz=%b want all 0",
                     Q, R, ready, busy, div_by_zero);
        end
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: got rdy=%b busy=%b want 0 0", ready, busy);
        end
        start_op(8'd100, 8'd7);
        wait_ready(lat);
        total++;
        if (lat !== NormLat || Q !== 8'h0E || R !== 8'h02) begin
            bad++;
            $display("FAIL reset_mid_rerun: got lat=%0d Q=%h R=%h want lat=%0d Q=0e R=02",
                     lat, Q, R, NormLat);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        start_op(8'd100, 8'd7);
        @(negedge clk);
        A = 8'd50;
        B = 8'hFA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        wait_ready(lat);
        total++;
        if (lat !== NormLat - 2 || Q !== 8'h0E || R !== 8'h02 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start: got lat=%0d Q=%h R=%h dbz=%b want lat=%0d Q=0e R=02",
                     lat, Q, R, div_by_zero, NormLat - 2);
        end
        // DONE must hold its result while start stays low.
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b1 || Q !== 8'h0E || R !== 8'h02) begin
            bad++;
            $display("FAIL done_hold: got rdy=%b Q=%h R=%h want 1 0e 02", ready, Q, R);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(8'd50, 8'hFA);
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b rdy=%b want 1 0", busy, ready);
        end
        wait_ready(lat);
        total++;
        if (lat !== NormLat || Q !== 8'hF8 || R !== 8'h02) begin
            bad++;
            $display("FAIL b2b: got lat=%0d Q=%h R=%h want lat=%0d Q=f8 R=02",
                     lat, Q, R, NormLat);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ez;
        int lat;
        for (int i = 0; i < 3000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            if (i % 16 == 0) a = 8'h80;
            if (i % 16 == 1) b = 8'hFF;
            if (i % 37 == 0) b = 8'h00;
            if (i % 23 == 0) a = 8'h00;
            ref_div(a, b, eq, er, ez);
            start_op(a, b);
            wait_ready(lat);
            total++;
            if (lat !== (ez ? 0 : NormLat)) begin
                bad++;
                $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, ez ? 0 : NormLat);
            end
            total++;
            if ({Q, R, div_by_zero} !== {eq, er, ez}) begin
                bad++;
                $display("FAIL rand%0d %0d/%0d: got Q=%h R=%h dbz=%b want Q=%h R=%h dbz=%b",
                         i, $signed(a), $signed(b), Q, R, div_by_zero, eq, er, ez);
            end
        end
        total++;
        if (n_overlap !== 0) begin
            bad++;
            $display("FAIL ready_busy_overlap: got %0d cycles want 0", n_overlap);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
